// File: rtl/gen_vidas_pkg.sv
// Shared constants for the lives overlay: heart geometry, colours and FSM states.
// Used by generador_vidas and forma_corazon.
package gen_vidas_pkg;

    localparam int unsigned N_BARS = 5;
    // Bar k covers dx in [BAR_W*k, BAR_W*k + BAR_W]; adjacent bars share one column
    localparam int unsigned BAR_W  = 5;

    localparam int unsigned BAR_DY_LO [N_BARS] = '{5, 0, 5, 0, 5};
    localparam int unsigned BAR_DY_HI [N_BARS] = '{15, 20, 25, 20, 15};

    localparam logic [2:0] COL_VIDA  = 3'b100;
    localparam logic [2:0] COL_GHOST = 3'b001;
    localparam logic [2:0] COL_OFF   = 3'b000;

    typedef enum logic [1:0] {
        VIVO,
        PARP,
        FIN
    } estado_t;

endpackage

// File: rtl/forma_corazon.sv
// Combinational heart-shape test: is (pix_x, pix_y) inside the heart whose
// top-left corner is (ox, oy)?
module forma_corazon
    import gen_vidas_pkg::*;
(
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [10:0] ox,
    input  logic [10:0] oy,
    output logic        in_shape
);

    logic [11:0] w_dx;
    logic [11:0] w_dy;

    assign w_dx = {2'b00, pix_x} - {1'b0, ox};
    assign w_dy = {2'b00, pix_y} - {1'b0, oy};

    // Bit 11 set means the pixel is left of / above the origin
    always_comb begin
        in_shape = 1'b0;
        if (!w_dx[11] && !w_dy[11]) begin
            for (int unsigned k = 0; k < N_BARS; k++) begin
                if (w_dx >= 12'(BAR_W * k) && w_dx <= 12'(BAR_W * k + BAR_W) &&
                    w_dy >= 12'(BAR_DY_LO[k]) && w_dy <= 12'(BAR_DY_HI[k])) begin
                    in_shape = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/generador_vidas.sv
// Lives indicator overlay: life counter FSM, heart-loss flash and heart drawing.
// Optional macro GEN_VIDAS_GHOST_EN draws lost hearts as dim blue ghosts.
module generador_vidas
    import gen_vidas_pkg::*;
#(
    parameter int unsigned MAX_VIDAS    = 3,
    parameter int unsigned HEART_X0     = 430,
    parameter int unsigned HEART_Y0     = 420,
    parameter int unsigned HEART_PITCH  = 40,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             video_on,
    input  logic [9:0]                       pix_x,
    input  logic [9:0]                       pix_y,
    input  logic                             refr_tick,
    input  logic                             hit,
    input  logic                             restart,
    output logic [$clog2(MAX_VIDAS+1)-1:0]   vidas,
    output logic                             game_over,
    output logic                             graph_on,
    output logic [2:0]                       graph_rgb
);

    localparam int unsigned VW = $clog2(MAX_VIDAS + 1);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

    estado_t         r_estado;
    logic [VW-1:0]   r_vidas;
    logic [BW-1:0]   r_blink;
    logic            r_game_over;

    logic [MAX_VIDAS-1:0] w_in;
    logic [MAX_VIDAS-1:0] w_rojo;
    logic [MAX_VIDAS-1:0] w_fantasma;

    for (genvar g = 0; g < MAX_VIDAS; g++) begin : g_corazon
        forma_corazon u_forma (
            .pix_x    (pix_x),
            .pix_y    (pix_y),
            .ox       (11'(HEART_X0 + g * HEART_PITCH)),
            .oy       (11'(HEART_Y0)),
            .in_shape (w_in[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= VIVO;
            r_vidas     <= VW'(MAX_VIDAS);
            r_blink     <= '0;
            r_game_over <= 1'b0;
        end else if (restart) begin
            r_estado    <= VIVO;
            r_vidas     <= VW'(MAX_VIDAS);
            r_blink     <= '0;
            r_game_over <= 1'b0;
        end else begin
            case (r_estado)
                VIVO: begin
                    if (hit) begin
                        r_vidas  <= r_vidas - VW'(1);
                        r_blink  <= BW'(BLINK_FRAMES);
                        r_estado <= PARP;
                    end
                end
                PARP: begin
                    if (refr_tick) begin
                        r_blink <= r_blink - BW'(1);
                        if (r_blink == BW'(1)) begin
                            if (r_vidas == '0) begin
                                r_estado    <= FIN;
                                r_game_over <= 1'b1;
                            end else begin
                                r_estado <= VIVO;
                            end
                        end
                    end
                end
                FIN: begin
                    r_game_over <= 1'b1;
                end
                default: begin
                    r_estado <= VIVO;
                end
            endcase
        end
    end

    // The heart at index == vidas is the one just lost; it flashes on blink bit 2
    always_comb begin
        w_rojo     = '0;
        w_fantasma = '0;
        for (int unsigned i = 0; i < MAX_VIDAS; i++) begin
            if (w_in[i]) begin
                if ((VW'(i) < r_vidas) ||
                    (r_estado == PARP && VW'(i) == r_vidas && r_blink[2])) begin
                    w_rojo[i] = 1'b1;
                end else begin
`ifdef GEN_VIDAS_GHOST_EN
                    w_fantasma[i] = 1'b1;
`else
                    w_fantasma[i] = 1'b0;
`endif
                end
            end
        end
    end

    assign graph_on = (|w_rojo) | (|w_fantasma);

    always_comb begin
        graph_rgb = COL_OFF;
        if (video_on && graph_on) begin
            graph_rgb = (|w_rojo) ? COL_VIDA : COL_GHOST;
        end
    end

    assign vidas     = r_vidas;
    assign game_over = r_game_over;

endmodule
